// File: rtl/serial_word_feeder_if.sv
// Parallel-in / serial-out bus for the word feeder: word handshake on the input side,
// serial bit stream plus completion status on the output side.
interface serial_word_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             done;
    logic [7:0]       word_cnt;

    // master = word producer / stream consumer, slave = the feeder itself
    modport master (
        output din, din_valid,
        input  din_ready, x, x_valid, done, word_cnt
    );
    modport slave (
        input  din, din_valid,
        output din_ready, x, x_valid, done, word_cnt
    );
endinterface

// File: rtl/serial_word_feeder.sv
// Serializes parallel words onto a 1-bit line for the sequence detector, with a
// one-word holding buffer so consecutive words stream without idle cycles.
module serial_word_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input logic clk,
    input logic rst,
    serial_word_feeder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] srShifted;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hold;
    logic             holdFull;
    logic [7:0]       wordCnt;
    logic             xBit;
    logic             lastBit;
    logic             xfer;

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        srShifted = sr;
        xBit      = 1'b0;
        if (MSB_FIRST) begin
            srShifted = {sr[WIDTH-2:0], 1'b0};
            xBit      = sr[WIDTH-1];
        end else begin
            srShifted = {1'b0, sr[WIDTH-1:1]};
            xBit      = sr[0];
        end
    end

    assign lastBit       = (state == SHIFT) && (cnt == LAST_CNT);
    assign bus.din_ready = rst & ~holdFull;
    assign xfer          = bus.din_valid & bus.din_ready;
    assign bus.x_valid   = (state == SHIFT);
    assign bus.x         = bus.x_valid ? xBit : IDLE_BIT;
    assign bus.done      = lastBit;
    assign bus.word_cnt  = wordCnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            holdFull <= 1'b0;
            wordCnt  <= '0;
        end else begin
            if (lastBit) begin
                wordCnt <= wordCnt + 8'd1;
            end
            case (state)
                IDLE: begin
                    if (xfer) begin
                        sr    <= bus.din;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                default: begin
                    if (!lastBit) begin
                        sr  <= srShifted;
                        cnt <= cnt + 1'b1;
                        if (xfer) begin
                            holdFull <= 1'b1;
                        end
                    end else if (holdFull) begin
                        // A buffered word always wins; din_ready is low so no new word competes.
                        sr       <= hold;
                        holdFull <= 1'b0;
                        cnt      <= '0;
                    end else if (xfer) begin
                        sr  <= bus.din;
                        cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // NOTE: hold is pure data qualified by holdFull, so it carries no reset.
    always_ff @(posedge clk) begin
        if (xfer && (state == SHIFT) && !lastBit) begin
            hold <= bus.din;
        end
    end
endmodule
